// File: rtl/v_hier_pkg.sv
// Shared types and helpers for the v_hier driver slice.
// Holds the driver state enum, default sizes and the signature rotate.
package v_hier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    FIN
  } state_e;

  localparam int WIDTH_DEF   = 4;
  localparam int LATENCY_DEF = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int SIG_W_DEF   = 8;

  // Rotate left by one within the low w bits (w <= 64).
  function automatic logic [63:0] rotl1(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/v_hier_dly.sv
// Valid shift pipe matching the sub-block latency.
// pend_o flags valids still in flight behind the output stage.
module v_hier_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_l,
  input  logic in_i,
  output logic out_o,
  output logic pend_o
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= in_i;
        end
      end
      assign pend_o = 1'b0;
    end else begin : g_many
      always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= {pipe_q[DEPTH-2:0], in_i};
        end
      end
      assign pend_o = |pipe_q[DEPTH-2:0];
    end
  endgenerate

  assign out_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/v_hier_drv.sv
// Burst driver for v_hier_sub: drives avec, captures qvec after
// LATENCY cycles and folds responses into a rotating signature.
module v_hier_drv
  import v_hier_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SIG_W   = SIG_W_DEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] avec,
  input  logic [WIDTH-1:0] qvec,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] rcount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] avec_q, avec_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [SIG_W-1:0] sig_rot;
  logic             push, vout, pend;

  assign push = (state_q == DRIVE);

  v_hier_dly #(
    .DEPTH (LATENCY)
  ) u_dly (
    .clk     (clk),
    .reset_l (reset_l),
    .in_i    (push),
    .out_o   (vout),
    .pend_o  (pend)
  );

  assign sig_rot = SIG_W'(rotl1(64'(sig_q), SIG_W));

  always_comb begin
    state_d = state_q;
    avec_d  = avec_q;
    rem_d   = rem_q;
    sig_d   = sig_q;
    rcnt_d  = rcnt_q;
    if (vout) begin
      sig_d  = sig_rot ^ SIG_W'(qvec);
      rcnt_d = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sig_d  = '0;
          rcnt_d = '0;
          if (count != '0) begin
            state_d = DRIVE;
            avec_d  = seed;
            rem_d   = count;
          end else begin
            state_d = FIN;
          end
        end
      end
      DRIVE: begin
        if (rem_q == CNT_ONE) begin
          state_d = DRAIN;
        end else begin
          rem_d  = rem_q - 1'b1;
          avec_d = avec_q + 1'b1;
        end
      end
      // Leave once only the output stage (if anything) remains.
      DRAIN: begin
        if (!pend) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      avec_q  <= '0;
      rem_q   <= '0;
      sig_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      avec_q  <= avec_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign avec   = avec_q;
  assign busy   = (state_q == DRIVE) || (state_q == DRAIN);
  assign done   = (state_q == FIN);
  assign sig    = sig_q;
  assign rcount = rcnt_q;

endmodule
